// File: rtl/im_loader_pkg.sv
// Shared definitions for the program loader, the instruction RAM and the PC block.
package im_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int WORD_W_DEF = 9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_LO    = 3'd2,
        S_HI    = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_e;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
interface im_loader_if #(
    parameter int ADDR_W = im_loader_pkg::ADDR_W_DEF,
    parameter int WORD_W = im_loader_pkg::WORD_W_DEF
);
    import im_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;

    // Host side: drives the stream and observes the RAM writes.
    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata
    );

endinterface

// File: rtl/im_loader_chk.sv
// Running XOR of accepted stream bytes; used only when IM_LOADER_CHECKSUM_EN is defined.
module im_loader_chk
    import im_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [BYTE_W-1:0] acc_o
);

    logic [BYTE_W-1:0] acc_q;

    // Accumulator register: clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {BYTE_W{1'b0}};
        end else if (clr_i) begin
            acc_q <= {BYTE_W{1'b0}};
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end else begin
            acc_q <= acc_q;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/im_loader.sv
// Program loader: parses count/lo/hi byte stream into instruction-RAM writes and holds the CPU
// until done. Optional trailing checksum byte under macro IM_LOADER_CHECKSUM_EN.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = WORD_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    im_loader_if.slave  bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam logic [31:0]       DEPTH   = 32'd1 << ADDR_W;
    // High-byte bits that do not fit in the instruction word.
    localparam logic [BYTE_W-1:0] HI_MASK = 8'hFF << (WORD_W - 8);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                in_ready_q, in_ready_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                accept_s;
    logic                last_s;
    logic                chk_clr_s;
    logic                chk_en_s;

    assign accept_s = bus.in_valid && in_ready_q;
    assign last_s   = (({1'b0, ptr_q} + (ADDR_W+1)'(1)) == count_q);

`ifdef IM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_acc_s;

    im_loader_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (chk_clr_s),
        .en_i   (chk_en_s),
        .data_i (bus.in_data),
        .acc_o  (chk_acc_s)
    );
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ptr_d     = ptr_q;
        lo_d      = lo_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        chk_clr_s = 1'b0;
        chk_en_s  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d   = S_COUNT;
                    ptr_d     = {ADDR_W{1'b0}};
                    chk_clr_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            S_COUNT: begin
                if (accept_s) begin
                    chk_en_s = 1'b1;
                    if ((bus.in_data != 8'd0) && ({24'd0, bus.in_data} <= DEPTH)) begin
                        count_d = (ADDR_W+1)'(bus.in_data);
                        state_d = S_LO;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_LO: begin
                if (accept_s) begin
                    chk_en_s = 1'b1;
                    lo_d     = bus.in_data;
                    state_d  = S_HI;
                end else begin
                    state_d = state_q;
                end
            end
            S_HI: begin
                if (accept_s) begin
                    chk_en_s = 1'b1;
                    if ((bus.in_data & HI_MASK) != 8'd0) begin
                        state_d = S_ERR;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = ptr_q;
                        wdata_d = WORD_W'({bus.in_data, lo_q});
                        ptr_d   = ptr_q + ADDR_W'(1);
                        if (last_s) begin
`ifdef IM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            state_d = S_LO;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept_s) begin
                    if (bus.in_data == chk_acc_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ERR;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_COUNT) || (state_d == S_LO) ||
                     (state_d == S_HI)    || (state_d == S_CHK);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= {(ADDR_W+1){1'b0}};
            ptr_q      <= {ADDR_W{1'b0}};
            lo_q       <= {BYTE_W{1'b0}};
            we_q       <= 1'b0;
            waddr_q    <= {ADDR_W{1'b0}};
            wdata_q    <= {WORD_W{1'b0}};
            in_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            lo_q       <= lo_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            in_ready_q <= in_ready_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
